mpc_seq: RTL and testbench

- Microprogram sequencer for the `mpc` operation unit.
- Holds a small program store of 18-bit `mpc` instructions (2-bit op, two 8-bit fields) and issues them one at a time to the externally instantiated `mpc`.
- Registers each 9-bit `mpc` result and offers it downstream on a valid/ready handshake.
- Software loads the program store, then pulses `start`. The block reports busy/done.

---
 rtl/mpc_pkg.sv | 32 +++
 rtl/mpc_seq_pmem.sv | 35 +++
 rtl/mpc_seq.sv | 165 ++++++++++++++++
 tb/tb_mpc_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_pkg.sv
// ============================================================================
//  Module   : mpc_pkg
//  Purpose  : Shared widths, opcode encodings and sequencer state type for
//             the mpc operation unit and its microprogram sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mpc_pkg;

    // Instruction and result widths of the mpc operation unit
    localparam int MPC_IW = 18;
    localparam int MPC_OW = 9;

    // Opcode encodings carried in instr[17:16]
    localparam logic [1:0] OP_00 = 2'b00;
    localparam logic [1:0] OP_01 = 2'b01;
    localparam logic [1:0] OP_10 = 2'b10;
    localparam logic [1:0] OP_11 = 2'b11;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        EXEC  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage : mpc_pkg

`default_nettype wire

// File: rtl/mpc_seq_pmem.sv
// ============================================================================
//  Module   : mpc_seq_pmem
//  Purpose  : DEPTH x IW program store, synchronous write, asynchronous read.
//             Contents are never reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mpc_seq_pmem #(
    parameter int AW    = 4,
    parameter int DEPTH = 2**AW,
    parameter int IW    = 18
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [IW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [IW-1:0] o_rd_data
);

    logic [IW-1:0] r_mem [DEPTH];

    // Write port: one word per cycle when enabled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : mpc_seq_pmem

`default_nettype wire

// File: rtl/mpc_seq.sv
// ============================================================================
//  Module   : mpc_seq
//  Purpose  : Microprogram sequencer for the mpc operation unit. Runs a
//             loaded program one instruction at a time (ISSUE/EXEC/WAIT) and
//             hands each result downstream on a valid/ready handshake.
//  Options  : MPC_SEQ_ACC_EN adds o_acc_sum, a 16-bit wrapping sum of all
//             accepted results of the current run.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mpc_seq
    import mpc_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DEPTH = 2**AW,
    parameter int IW    = MPC_IW,
    parameter int OW    = MPC_OW
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef MPC_SEQ_ACC_EN
    output logic [15:0]   o_acc_sum,
`endif
    input  logic          i_prog_we,
    input  logic [AW-1:0] i_prog_addr,
    input  logic [IW-1:0] i_prog_data,
    input  logic [AW:0]   i_prog_len,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [IW-1:0] o_mpc_instr,
    input  logic [OW-1:0] i_mpc_out,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [OW-1:0] o_res_data,
    output logic [AW-1:0] o_res_idx
);

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_len_q;
    logic [IW-1:0] r_mpc_instr;
    logic          r_res_valid;
    logic [OW-1:0] r_res_data;
    logic [AW-1:0] r_res_idx;
    logic          r_busy;
    logic          r_done;
`ifdef MPC_SEQ_ACC_EN
    logic [15:0]   r_acc_sum;
`endif

    logic          w_we;
    logic [IW-1:0] w_rd_data;
    logic [AW:0]   w_len_clamped;
    logic          w_last;

    // The store is only writable while no program is running
    assign w_we = i_prog_we && (r_state == IDLE);

    // Lengths beyond the store size run the whole store
    assign w_len_clamped = (i_prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : i_prog_len;

    // Final instruction of the run; pc never wraps past it
    assign w_last = ({1'b0, r_pc} == (r_len_q - (AW+1)'(1)));

    mpc_seq_pmem #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_pmem (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (i_prog_addr),
        .i_wr_data (i_prog_data),
        .i_rd_addr (r_pc),
        .o_rd_data (w_rd_data)
    );

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_len_q     <= '0;
            r_mpc_instr <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef MPC_SEQ_ACC_EN
            r_acc_sum   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_pc   <= '0;
                        r_busy <= 1'b1;
`ifdef MPC_SEQ_ACC_EN
                        r_acc_sum <= '0;
`endif
                        if (i_prog_len == '0) begin
                            // Empty program: straight to the done pulse
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_len_q <= w_len_clamped;
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_mpc_instr <= w_rd_data;
                    r_state     <= EXEC;
                end
                EXEC: begin
                    // mpc has had a full cycle to settle on r_mpc_instr
                    r_res_data  <= i_mpc_out;
                    r_res_idx   <= r_pc;
                    r_res_valid <= 1'b1;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
`ifdef MPC_SEQ_ACC_EN
                        r_acc_sum <= r_acc_sum + 16'(r_res_data);
`endif
                        if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_pc    <= r_pc + AW'(1);
                            r_state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_mpc_instr = r_mpc_instr;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_idx   = r_res_idx;
`ifdef MPC_SEQ_ACC_EN
    assign o_acc_sum   = r_acc_sum;
`endif

endmodule : mpc_seq

`default_nettype wire

// File: tb/tb_mpc_seq.sv
// ============================================================================
//  Module   : tb_mpc_seq
//  Purpose  : Self-checking bench for mpc_seq. An mpc stub returns
//             instr[8:0]; expected (idx,data) pairs are queued at start and
//             popped by a monitor whenever a result is accepted.
//  Options  : MPC_SEQ_ACC_EN enables the accumulator checks.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mpc_seq;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int IW    = 18;
    localparam int OW    = 9;

    typedef struct {
        logic [AW-1:0] idx;
        logic [OW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [IW-1:0] mpc_instr;
    logic [OW-1:0] mpc_out;
    logic          res_valid;
    logic          rdy = 1'b1;
    logic [OW-1:0] res_data;
    logic [AW-1:0] res_idx;
`ifdef MPC_SEQ_ACC_EN
    logic [15:0]   acc_sum;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    exp_t          q[$];
    logic [IW-1:0] mem_m [DEPTH];
    logic [15:0]   acc_m = '0;
    int            rdy_mode = 0;
    int            stall_left = 0;

    always #5 clk = ~clk;

    // mpc stub: result is the low nine instruction bits
    assign mpc_out = mpc_instr[OW-1:0];

    mpc_seq #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .IW    (IW),
        .OW    (OW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef MPC_SEQ_ACC_EN
        .o_acc_sum   (acc_sum),
`endif
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr),
        .i_prog_data (prog_data),
        .i_prog_len  (prog_len),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_mpc_instr (mpc_instr),
        .i_mpc_out   (mpc_out),
        .o_res_valid (res_valid),
        .i_res_ready (rdy),
        .o_res_data  (res_data),
        .o_res_idx   (res_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: 0 = always, 1 = random, 2 = stall the idx 1 result
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1: rdy = ($urandom_range(0, 3) != 0);
                2: begin
                    if (res_valid && res_idx == AW'(1) && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else begin
                        rdy = 1'b1;
                    end
                end
                default: rdy = 1'b1;
            endcase
        end
    end

    // Scoreboard monitor: compare each accepted result with the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && rdy) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got idx %0d data %0h expected none", res_idx, res_data);
                end else begin
                    e = q.pop_front();
                    check("res_idx", 32'(res_idx), 32'(e.idx));
                    check("res_data", 32'(res_data), 32'(e.data));
                    acc_m = acc_m + 16'(e.data);
                end
            end
            if (rst_n && done) begin
                check("done_with_valid", 32'(res_valid), 32'd0);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load(input int addr, input logic [IW-1:0] data);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = data;
        @(posedge clk);
        #1;
        prog_we   = 1'b0;
        mem_m[addr] = data;
    endtask

    // Queue the expected results of a run and issue the start pulse
    task automatic kick(input int len);
        int n;
        exp_t e;
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++) begin
            e.idx  = AW'(i);
            e.data = mem_m[i][OW-1:0];
            q.push_back(e);
        end
        acc_m    = '0;
        prog_len = (AW+1)'(len);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Run a program; exp_cyc < 0 only enforces the 3N+1 minimum
    task automatic run(input int len, input int exp_cyc, input bit poke);
        int cyc;
        int n;
        bit timed_out;
        n = (len > DEPTH) ? DEPTH : len;
        kick(len);
        cyc = 0;
        timed_out = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            check("busy_in_run", 32'(busy), 32'd1);
`ifdef MPC_SEQ_ACC_EN
            if (cyc == 1) check("acc_cleared", 32'(acc_sum), 32'd0);
`endif
            if (res_valid && !rdy && q.size() > 0) begin
                check("stall_data", 32'(res_data), 32'(q[0].data));
                check("stall_idx", 32'(res_idx), 32'(q[0].idx));
                check("stall_instr", 32'(mpc_instr), 32'(mem_m[q[0].idx]));
            end
            if (poke && cyc == 2) begin
                prog_we   = 1'b1;
                prog_addr = '0;
                prog_data = 18'h3FFFF;
                prog_len  = (AW+1)'(1);
                start     = 1'b1;
            end
            if (poke && cyc == 3) begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            if (done) break;
            if (cyc > 3000) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (timed_out) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout: got no done after %0d cycles expected done", cyc);
        end else if (exp_cyc >= 0) begin
            check("run_cycles", 32'(cyc), 32'(exp_cyc));
        end else begin
            check("run_cycles_min", 32'(cyc >= 3 * n + 1), 32'd1);
        end
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("queue_drained", 32'(q.size()), 32'd0);
`ifdef MPC_SEQ_ACC_EN
        check("acc_sum", 32'(acc_sum), 32'(acc_m));
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_instr", 32'(mpc_instr), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_idx", 32'(res_idx), 32'd0);
`ifdef MPC_SEQ_ACC_EN
        check("rst_acc", 32'(acc_sum), 32'd0);
`endif
    endtask

    initial begin
        // Power-on reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        load(0, 18'b00_01001101_00101111);
        load(1, 18'b00_11001101_11101111);
        load(2, 18'b11_11001101_00101111);

        // Basic three-word run: done 10 cycles after the start edge
        run(3, 10, 1'b0);
`ifdef MPC_SEQ_ACC_EN
        check("acc_3w", 32'(acc_sum), 32'h044D);
`endif

        // Backpressure on the idx 1 result for 5 cycles
        rdy_mode   = 2;
        stall_left = 5;
        run(3, 15, 1'b0);
        rdy_mode   = 0;

        // Empty program
        run(0, 1, 1'b0);

        // Store write and second start during a run are both ignored
        run(3, 10, 1'b1);
        run(1, 4, 1'b0);

        // Reset in the middle of a run
        kick(3);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(1, 4, 1'b0);

        // Randomised programs, lengths (including clamping) and ready
        for (int it = 0; it < 10; it++) begin
            int len;
            for (int a = 0; a < DEPTH; a++) begin
                load(a, IW'($urandom));
            end
            len = $urandom_range(0, 20);
            if (it % 2 == 0) begin
                rdy_mode = 0;
                run(len, 3 * ((len > DEPTH) ? DEPTH : len) + 1, 1'b0);
            end else begin
                rdy_mode = 1;
                run(len, -1, 1'b0);
            end
        end
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mpc_seq

`default_nettype wire
